// File: rtl/seq_add_mul_unit.sv
// Sequential W-bit add (1 cycle) / shift-and-add multiply (W cycles) behind valid/ready handshakes.
// Optional multiply-accumulate enabled with macro SEQ_ADD_MUL_ACC_EN.
module seq_add_mul_unit #(
    parameter int unsigned W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  result,
    output logic            err,
    output logic            busy
);

    localparam int unsigned RW = 2 * W;
    localparam int unsigned SW = W + 1;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    mcand;
    logic [W-1:0]    mplier;
    logic [RW-1:0]   prod;
    logic [CW-1:0]   cnt;

    logic [SW-1:0]   sum_c;
    logic [RW-1:0]   prod_next_c;
    logic            start_mul_c;
    logic            err_op_c;
    logic            mul_last_c;

    // One shift-and-add step; multiplicand is widened before shifting so nothing is lost.
    always_comb begin
        sum_c       = SW'(a) + SW'(b);
        prod_next_c = mplier[0] ? (prod + (RW'(mcand) << cnt)) : prod;
        mul_last_c  = (cnt == CW'(W - 1));
    end

`ifdef SEQ_ADD_MUL_ACC_EN
    logic [RW-1:0]   acc;
    logic            is_mac;
    logic [RW-1:0]   acc_sum_c;

    always_comb begin
        start_mul_c = (op == 2'b01) || (op == 2'b10);
        err_op_c    = 1'b0;
        acc_sum_c   = acc + prod_next_c;
    end
`else
    always_comb begin
        start_mul_c = (op == 2'b01);
        err_op_c    = op[1];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
`ifdef SEQ_ADD_MUL_ACC_EN
            acc       <= '0;
            is_mac    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        mcand    <= a;
                        mplier   <= b;
                        prod     <= '0;
                        cnt      <= '0;
                        if (op == 2'b00) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= RW'(sum_c);
                            err       <= 1'b0;
                        end else if (start_mul_c) begin
                            state <= S_MUL;
`ifdef SEQ_ADD_MUL_ACC_EN
                            is_mac <= op[1];
`endif
                        end else begin
                            // Clear (accumulator build) or unsupported op: immediate result of 0.
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= '0;
                            err       <= err_op_c;
`ifdef SEQ_ADD_MUL_ACC_EN
                            acc       <= '0;
`endif
                        end
                    end
                end

                S_MUL: begin
                    prod   <= prod_next_c;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (mul_last_c) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        err       <= 1'b0;
`ifdef SEQ_ADD_MUL_ACC_EN
                        if (is_mac) begin
                            acc    <= acc_sum_c;
                            result <= acc_sum_c;
                        end else begin
                            result <= prod_next_c;
                        end
`else
                        result    <= prod_next_c;
`endif
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
